// File: rtl/video_timing_gen_if.sv
// Raster timing bus: the generator drives it (master), the video pipeline
// stages consume it (slave).
interface video_timing_gen_if #(
  parameter int H_W     = 9,
  parameter int V_W     = 9,
  parameter int FRAME_W = 8
);
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               hblank;
  logic               vblank;
  logic [H_W-1:0]     hpos;
  logic [V_W-1:0]     vpos;
  logic               pix_ce;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output hsync, vsync, display_on, hblank, vblank,
    output hpos, vpos, pix_ce, line_start, frame_start, frame_count
  );

  modport slave (
    input hsync, vsync, display_on, hblank, vblank,
    input hpos, vpos, pix_ce, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable divider, h/v beam
// counters, frame counter and zero-lag decode of sync, blanking and strobes.
module video_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_BACK    = 23,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_TOP     = 5,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int H_W       = 9,
  parameter int V_W       = 9,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  video_timing_gen_if.master vid
);
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int H_MAX    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int VS_START = V_DISPLAY + V_BOTTOM;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int V_MAX    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [H_W-1:0]   H_DISP_C   = H_W'(H_DISPLAY);
  localparam logic [H_W-1:0]   HS_START_C = H_W'(HS_START);
  localparam logic [H_W-1:0]   HS_END_C   = H_W'(HS_END);
  localparam logic [H_W-1:0]   H_MAX_C    = H_W'(H_MAX);
  localparam logic [V_W-1:0]   V_DISP_C   = V_W'(V_DISPLAY);
  localparam logic [V_W-1:0]   VS_START_C = V_W'(VS_START);
  localparam logic [V_W-1:0]   VS_END_C   = V_W'(VS_END);
  localparam logic [V_W-1:0]   V_MAX_C    = V_W'(V_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q,   div_d;
  logic [H_W-1:0]     hpos_q,  hpos_d;
  logic [V_W-1:0]     vpos_q,  vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic pix_ce_s;
  logic hs_act_s;
  logic vs_act_s;
  logic line_start_s;
  logic frame_start_s;
  logic hblank_s;
  logic vblank_s;

  // Divider next state; pix_ce is suppressed while reset is held
  always_comb begin
    div_d    = div_q;
    pix_ce_s = 1'b0;
    if (reset) begin
      div_d    = '0;
      pix_ce_s = 1'b0;
    end else begin
      pix_ce_s = (div_q == DIV_LAST);
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Beam and frame counters advance only on pixel enables
  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (pix_ce_s) begin
      if (hpos_q == H_MAX_C) begin
        hpos_d = '0;
        if (vpos_q == V_MAX_C) begin
          vpos_d  = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          vpos_d = vpos_q + V_W'(1);
        end
      end else begin
        hpos_d = hpos_q + H_W'(1);
      end
    end else begin
      hpos_d  = hpos_q;
      vpos_d  = vpos_q;
      frame_d = frame_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
    end
  end

  // Decode straight from the live counters so nothing lags hpos/vpos
  always_comb begin
    hblank_s      = (hpos_q >= H_DISP_C);
    vblank_s      = (vpos_q >= V_DISP_C);
    hs_act_s      = 1'b0;
    vs_act_s      = 1'b0;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;
    if (reset) begin
      hs_act_s      = 1'b0;
      vs_act_s      = 1'b0;
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end else begin
      hs_act_s      = (hpos_q >= HS_START_C) && (hpos_q <= HS_END_C);
      vs_act_s      = (vpos_q >= VS_START_C) && (vpos_q <= VS_END_C);
      line_start_s  = pix_ce_s && (hpos_q == '0);
      frame_start_s = line_start_s && (vpos_q == '0);
    end
  end

  assign vid.hsync       = hs_act_s ? HSYNC_POL : ~HSYNC_POL;
  assign vid.vsync       = vs_act_s ? VSYNC_POL : ~VSYNC_POL;
  assign vid.hblank      = hblank_s;
  assign vid.vblank      = vblank_s;
  assign vid.display_on  = ~hblank_s & ~vblank_s;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.pix_ce      = pix_ce_s;
  assign vid.line_start  = line_start_s;
  assign vid.frame_start = frame_start_s;
  assign vid.frame_count = frame_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a default-geometry instance and a small
// inverted-polarity, divide-by-3, 2-bit-frame instance, both under random resets.
module tb_video_timing_gen;
  typedef struct {
    int hd, hb, hf, hs;
    int vd, vt, vbo, vs;
    int hp, vp;
    int div, fw;
  } geom_t;

  typedef struct {
    int hpos, vpos, fc;
    int pix_ce, ls, fs;
    int hs, vs, don, hbl, vbl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  video_timing_gen_if #(.H_W(9), .V_W(9), .FRAME_W(8)) vif_a ();
  video_timing_gen_if #(.H_W(4), .V_W(3), .FRAME_W(2)) vif_b ();

  video_timing_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vid   (vif_a.master)
  );

  video_timing_gen #(
    .H_DISPLAY (8),
    .H_BACK    (2),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .V_DISPLAY (4),
    .V_TOP     (1),
    .V_BOTTOM  (1),
    .V_SYNC    (1),
    .H_W       (4),
    .V_W       (3),
    .HSYNC_POL (1'b0),
    .VSYNC_POL (1'b0),
    .CLK_DIV   (3),
    .FRAME_W   (2)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vid   (vif_b.master)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference: k = clk edges since the last reset edge; each CLK_DIV-th clk is a pixel.
  function automatic exp_t model(geom_t g, int k, bit rst);
    exp_t e;
    int   ht, vt, t, lines;
    bit   hs_on, vs_on;
    ht    = g.hd + g.hb + g.hf + g.hs;
    vt    = g.vd + g.vt + g.vbo + g.vs;
    t     = k / g.div;
    e.hpos   = t % ht;
    lines    = t / ht;
    e.vpos   = lines % vt;
    e.fc     = (lines / vt) % (1 << g.fw);
    e.pix_ce = (!rst && ((k % g.div) == g.div - 1)) ? 1 : 0;
    e.ls     = (e.pix_ce == 1 && e.hpos == 0) ? 1 : 0;
    e.fs     = (e.ls == 1 && e.vpos == 0) ? 1 : 0;
    hs_on    = !rst && e.hpos >= g.hd + g.hf && e.hpos < g.hd + g.hf + g.hs;
    vs_on    = !rst && e.vpos >= g.vd + g.vbo && e.vpos < g.vd + g.vbo + g.vs;
    e.hs     = hs_on ? g.hp : 1 - g.hp;
    e.vs     = vs_on ? g.vp : 1 - g.vp;
    e.hbl    = (e.hpos >= g.hd) ? 1 : 0;
    e.vbl    = (e.vpos >= g.vd) ? 1 : 0;
    e.don    = (e.hbl == 0 && e.vbl == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input string what, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s.%s at %0t: got %0d, expected %0d", tag, what, $time, act, exp);
    end
  endtask

  task automatic compare_set(input string tag, input exp_t e, input int hpos, input int vpos,
                             input int fc, input int pix_ce, input int ls, input int fs,
                             input int hs, input int vs, input int don, input int hbl,
                             input int vbl);
    chk(tag, "hpos", hpos, e.hpos);
    chk(tag, "vpos", vpos, e.vpos);
    chk(tag, "frame_count", fc, e.fc);
    chk(tag, "pix_ce", pix_ce, e.pix_ce);
    chk(tag, "line_start", ls, e.ls);
    chk(tag, "frame_start", fs, e.fs);
    chk(tag, "hsync", hs, e.hs);
    chk(tag, "vsync", vs, e.vs);
    chk(tag, "display_on", don, e.don);
    chk(tag, "hblank", hbl, e.hbl);
    chk(tag, "vblank", vbl, e.vbl);
  endtask

  // Monitor: pop the expected response for each presented cycle and compare
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      compare_set("A", e, int'(vif_a.hpos), int'(vif_a.vpos), int'(vif_a.frame_count),
                  int'(vif_a.pix_ce), int'(vif_a.line_start), int'(vif_a.frame_start),
                  int'(vif_a.hsync), int'(vif_a.vsync), int'(vif_a.display_on),
                  int'(vif_a.hblank), int'(vif_a.vblank));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare_set("B", e, int'(vif_b.hpos), int'(vif_b.vpos), int'(vif_b.frame_count),
                  int'(vif_b.pix_ce), int'(vif_b.line_start), int'(vif_b.frame_start),
                  int'(vif_b.hsync), int'(vif_b.vsync), int'(vif_b.display_on),
                  int'(vif_b.hblank), int'(vif_b.vblank));
    end
  end

  // Stimulus: random reset pulses; after every edge push the expected view
  initial begin
    geom_t ga, gb;
    int    k_a, k_b, hold_a, hold_b;
    ga = '{hd: 256, hb: 23, hf: 7, hs: 23, vd: 240, vt: 5, vbo: 14, vs: 3,
           hp: 1, vp: 1, div: 1, fw: 8};
    gb = '{hd: 8, hb: 2, hf: 1, hs: 2, vd: 4, vt: 1, vbo: 1, vs: 1,
           hp: 0, vp: 0, div: 3, fw: 2};
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    k_a    = 0;
    k_b    = 0;
    hold_a = 2;
    hold_b = 2;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(posedge clk);
      if (rst_a) k_a = 0; else k_a++;
      if (rst_b) k_b = 0; else k_b++;
      #1;
      if (hold_a > 0) begin
        hold_a--;
        rst_a = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        rst_a  = 1'b1;
        hold_a = $urandom_range(0, 3);
      end else begin
        rst_a = 1'b0;
      end
      if (hold_b > 0) begin
        hold_b--;
        rst_b = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        rst_b  = 1'b1;
        hold_b = $urandom_range(0, 3);
      end else begin
        rst_b = 1'b0;
      end
      q_a.push_back(model(ga, k_a, rst_a));
      q_b.push_back(model(gb, k_b, rst_b));
    end
    @(negedge clk);
    #1;
    chk("A", "queue_drained", q_a.size(), 0);
    chk("B", "queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
